// File: rtl/telemeter_system_pkg.sv
// Shared types and register map for the echo ranger.
// States, addresses, bit indices and the timeout marker.
package telemeter_system_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE
  } state_e;

  localparam logic [1:0] ADDR_STATUS   = 2'd0;
  localparam logic [1:0] ADDR_CONTROL  = 2'd1;
  localparam logic [1:0] ADDR_RESULT_L = 2'd2;
  localparam logic [1:0] ADDR_RESULT_H = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;

  localparam int CT_IRQ_EN = 0;
  localparam int CT_AUTO   = 1;
  localparam int CT_START  = 2;

  localparam logic [31:0] RESULT_TIMEOUT = 32'hFFFF_FFFF;

endpackage

// File: rtl/telemeter_system_sync_edge.sv
// Optional N-flop synchronizer followed by an edge register.
// DEPTH=0 edge-detects a same-domain signal directly.
module telemeter_system_sync_edge #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic prev;

  if (DEPTH == 0) begin : g_direct
    assign level = din;
  end else begin : g_sync
    logic [DEPTH-1:0] sq;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        sq <= '0;
      end else begin
        sq[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          sq[i] <= sq[i-1];
        end
      end
    end

    assign level = sq[DEPTH-1];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev <= 1'b0;
    end else begin
      prev <= level;
    end
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/telemeter_system_echo_ranger.sv
// Ultrasonic ranger: timer-launched trigger pulse, echo width
// measurement with timeout, Avalon-MM register slave and irq.
module telemeter_system_echo_ranger
  import telemeter_system_pkg::*;
#(
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1_500_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick_in,
  input  logic        echo_in,
  output logic        trig_out,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam int TW  = $clog2(TRIG_CYCLES + 1);
  localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TRIG_LAST = TW'(TRIG_CYCLES - 1);
  localparam logic [TMW-1:0] TMO_LAST  = TMW'(TIMEOUT_CYCLES - 1);

  state_e         state, state_n;
  logic [TW-1:0]  trig_cnt, trig_cnt_n;
  logic [TMW-1:0] tmo_cnt, tmo_cnt_n;
  logic [31:0]    wid_cnt, wid_cnt_n;
  logic [31:0]    result;
  logic           cmp_ok, cmp_tmo;
  logic           done, tout, irq_en, auto_en;
  logic           tick_rise, echo_lvl, echo_rise, echo_fall;
  logic           tick_lvl_unused, tick_fall_unused;
  logic [12:0]    wdata_unused;
  logic           wr, wr_stat, wr_ctrl, start_req, busy;
  logic [15:0]    rd_mux;

  telemeter_system_sync_edge #(.DEPTH(0)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (tick_in),
    .level   (tick_lvl_unused),
    .rise    (tick_rise),
    .fall    (tick_fall_unused)
  );

  telemeter_system_sync_edge #(.DEPTH(2)) u_echo (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (echo_in),
    .level   (echo_lvl),
    .rise    (echo_rise),
    .fall    (echo_fall)
  );

  assign wdata_unused = writedata[15:3];
  assign wr        = chipselect & ~write_n;
  assign wr_stat   = wr & (address == ADDR_STATUS);
  assign wr_ctrl   = wr & (address == ADDR_CONTROL);
  // auto is the registered value, so a same-cycle clear still sees the tick
  assign start_req = (auto_en & tick_rise)
                   | (wr_ctrl & writedata[CT_START]);
  assign busy      = (state != IDLE);
  assign irq       = irq_en & done;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      trig_cnt <= '0;
      tmo_cnt  <= '0;
      wid_cnt  <= '0;
      trig_out <= 1'b0;
    end else begin
      state    <= state_n;
      trig_cnt <= trig_cnt_n;
      tmo_cnt  <= tmo_cnt_n;
      wid_cnt  <= wid_cnt_n;
      trig_out <= (state_n == TRIG);
    end
  end

  always_comb begin
    state_n    = state;
    trig_cnt_n = trig_cnt;
    tmo_cnt_n  = tmo_cnt;
    wid_cnt_n  = wid_cnt;
    cmp_ok     = 1'b0;
    cmp_tmo    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_req) begin
          state_n    = TRIG;
          trig_cnt_n = '0;
        end
      end
      TRIG: begin
        if (trig_cnt == TRIG_LAST) begin
          state_n   = WAIT_RISE;
          tmo_cnt_n = '0;
        end else begin
          trig_cnt_n = trig_cnt + 1'b1;
        end
      end
      WAIT_RISE: begin
        if (tmo_cnt == TMO_LAST) begin
          state_n = IDLE;
          cmp_tmo = 1'b1;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
          if (echo_rise) begin
            state_n   = MEASURE;
            wid_cnt_n = 32'd1;
          end
        end
      end
      MEASURE: begin
        // a fall on the last allowed cycle still counts as a measurement
        if (echo_fall) begin
          state_n = IDLE;
          cmp_ok  = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          state_n = IDLE;
          cmp_tmo = 1'b1;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
          if (echo_lvl) begin
            wid_cnt_n = wid_cnt + 32'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      ADDR_STATUS: begin
        rd_mux[ST_BUSY]    = busy;
        rd_mux[ST_DONE]    = done;
        rd_mux[ST_TIMEOUT] = tout;
      end
      ADDR_CONTROL: begin
        rd_mux[CT_IRQ_EN] = irq_en;
        rd_mux[CT_AUTO]   = auto_en;
      end
      ADDR_RESULT_L: rd_mux = result[15:0];
      ADDR_RESULT_H: rd_mux = result[31:16];
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      done     <= 1'b0;
      tout     <= 1'b0;
      irq_en   <= 1'b0;
      auto_en  <= 1'b0;
      result   <= '0;
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
      if (wr_ctrl) begin
        irq_en  <= writedata[CT_IRQ_EN];
        auto_en <= writedata[CT_AUTO];
      end
      if (wr_stat) begin
        done <= 1'b0;
        tout <= 1'b0;
      end
      // completion overrides a same-cycle STATUS clear
      if (cmp_ok | cmp_tmo) begin
        done   <= 1'b1;
        result <= cmp_tmo ? RESULT_TIMEOUT : wid_cnt;
      end
      if (cmp_tmo) begin
        tout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_telemeter_system_echo_ranger.sv
// Directed bench for the echo ranger with short trigger/timeout.
// Hand-computed expectations; one summary line at the end.
module tb_telemeter_system_echo_ranger;

  localparam logic [1:0] A_STAT = 2'd0;
  localparam logic [1:0] A_CTRL = 2'd1;
  localparam logic [1:0] A_RL   = 2'd2;
  localparam logic [1:0] A_RH   = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tick_in;
  logic        echo_in;
  logic        trig_out;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  int n_chk = 0;
  int n_err = 0;
  int trig_rises = 0;
  int irq_rises = 0;
  logic trig_q = 1'b0;
  logic irq_q = 1'b0;

  telemeter_system_echo_ranger #(
    .TRIG_CYCLES    (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick_in    (tick_in),
    .echo_in    (echo_in),
    .trig_out   (trig_out),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (trig_out && !trig_q) trig_rises++;
    if (irq && !irq_q) irq_rises++;
    trig_q = trig_out;
    irq_q  = irq;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    cyc(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    address = a;
    cyc(1);
    d = readdata;
  endtask

  task automatic shot(input int w, input bit poke, output int tlen);
    int n;
    n = 0;
    tlen = 0;
    while (!trig_out && n < 20) begin
      cyc(1);
      n++;
    end
    chk("trig_seen", {31'd0, trig_out}, 32'd1);
    while (trig_out && tlen < 50) begin
      tlen++;
      cyc(1);
    end
    echo_in = 1'b1;
    for (int i = 0; i < w; i++) begin
      if (poke && i == 10) begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = A_CTRL;
        writedata  = 16'h0007;
        tick_in    = 1'b1;
      end
      if (poke && i == 11) begin
        chipselect = 1'b0;
        write_n    = 1'b1;
        tick_in    = 1'b0;
      end
      cyc(1);
    end
    echo_in = 1'b0;
    cyc(8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    int tl, tr0, ir0;
    reset_n    = 1'b0;
    tick_in    = 1'b0;
    echo_in    = 1'b0;
    address    = A_STAT;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_trig", {31'd0, trig_out}, 32'd0);
    chk("rst_rdata", {16'd0, readdata}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    rd(A_STAT, d);
    chk("rst_status", {16'd0, d}, 32'd0);
    rd(A_CTRL, d);
    chk("rst_ctrl", {16'd0, d}, 32'd0);

    // software start, 20-cycle echo
    wr(A_CTRL, 16'h0004);
    shot(20, 1'b0, tl);
    chk("t1_trig_len", tl, 32'd4);
    rd(A_STAT, d);
    chk("t1_status", {16'd0, d}, 32'h2);
    chk("t1_irq", {31'd0, irq}, 32'd0);
    rd(A_RL, d);
    chk("t1_res_l", {16'd0, d}, 32'd20);
    rd(A_RH, d);
    chk("t1_res_h", {16'd0, d}, 32'd0);
    rd(A_CTRL, d);
    chk("t1_ctrl", {16'd0, d}, 32'd0);

    // tick-launched, irq enabled, 37-cycle echo
    wr(A_STAT, 16'h0000);
    wr(A_CTRL, 16'h0003);
    cyc(3);
    chk("t2_no_auto", {31'd0, trig_out}, 32'd0);
    tick_in = 1'b1;
    cyc(1);
    tick_in = 1'b0;
    shot(37, 1'b0, tl);
    chk("t2_trig_len", tl, 32'd4);
    chk("t2_irq_set", {31'd0, irq}, 32'd1);
    wr(A_STAT, 16'h0000);
    chk("t2_irq_clr", {31'd0, irq}, 32'd0);
    rd(A_RL, d);
    chk("t2_res_l", {16'd0, d}, 32'd37);
    rd(A_STAT, d);
    chk("t2_status", {16'd0, d}, 32'h0);

    // no echo at all: timeout
    wr(A_CTRL, 16'h0004);
    cyc(98);
    rd(A_STAT, d);
    chk("t3_busy", {16'd0, d}, 32'h1);
    cyc(10);
    rd(A_STAT, d);
    chk("t3_status", {16'd0, d}, 32'h6);
    rd(A_RL, d);
    chk("t3_res_l", {16'd0, d}, 32'hFFFF);
    rd(A_RH, d);
    chk("t3_res_h", {16'd0, d}, 32'hFFFF);

    // echo stuck high across the whole window
    wr(A_STAT, 16'h0000);
    echo_in = 1'b1;
    cyc(6);
    wr(A_CTRL, 16'h0004);
    cyc(110);
    rd(A_STAT, d);
    chk("t4_status", {16'd0, d}, 32'h6);
    rd(A_RL, d);
    chk("t4_res_l", {16'd0, d}, 32'hFFFF);
    echo_in = 1'b0;
    cyc(6);

    // restart attempts during MEASURE are dropped
    wr(A_STAT, 16'h0000);
    cyc(2);
    tr0 = trig_rises;
    ir0 = irq_rises;
    wr(A_CTRL, 16'h0007);
    shot(30, 1'b1, tl);
    cyc(20);
    chk("t5_trig_rises", trig_rises - tr0, 32'd1);
    chk("t5_completions", irq_rises - ir0, 32'd1);
    rd(A_RL, d);
    chk("t5_res_l", {16'd0, d}, 32'd30);
    rd(A_STAT, d);
    chk("t5_status", {16'd0, d}, 32'h2);

    // reset in the middle of TRIG
    wr(A_STAT, 16'h0000);
    wr(A_CTRL, 16'h0004);
    chk("t6_trig_on", {31'd0, trig_out}, 32'd1);
    reset_n = 1'b0;
    cyc(1);
    chk("t6_trig_off", {31'd0, trig_out}, 32'd0);
    chk("t6_rdata", {16'd0, readdata}, 32'd0);
    chk("t6_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    rd(A_STAT, d);
    chk("t6_status", {16'd0, d}, 32'h0);
    rd(A_RL, d);
    chk("t6_res_l", {16'd0, d}, 32'd0);
    cyc(10);
    chk("t6_no_retrig", {31'd0, trig_out}, 32'd0);
    wr(A_CTRL, 16'h0004);
    shot(12, 1'b0, tl);
    chk("t6_trig_len", tl, 32'd4);
    rd(A_RL, d);
    chk("t6_res_new", {16'd0, d}, 32'd12);
    rd(A_STAT, d);
    chk("t6_status_new", {16'd0, d}, 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
